alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters using round-robin grants.
// Each requester has its own status context, which is fed to the ALU and updated from it.
module alu_arbiter #(
    parameter logic [4:0] STATUS_INIT = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [4:0]  req0_op,
    input  logic [4:0]  req1_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_op,
    output logic [4:0]  alu_status_in,
    input  logic [15:0] alu_c0,
    input  logic [15:0] alu_c1,
    input  logic [4:0]  alu_status_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_c0,
    output logic [15:0] rsp_c1,
    output logic [4:0]  rsp_status,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_grant_r;
    logic        grant_id_r;
    logic [4:0]  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [4:0]  ctx0_r;
    logic [4:0]  ctx1_r;
    logic        rsp_id_r;
    logic [15:0] rsp_c0_r;
    logic [15:0] rsp_c1_r;
    logic [4:0]  rsp_status_r;
    logic        any_req_s;
    logic        pick_s;
    logic        accept_s;
    logic        capture_s;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        any_req_s = 1'b0;
        pick_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            any_req_s = 1'b1;
            pick_s    = ~last_grant_r;
        end else if (req0_valid) begin
            any_req_s = 1'b1;
            pick_s    = 1'b0;
        end else if (req1_valid) begin
            any_req_s = 1'b1;
            pick_s    = 1'b1;
        end else begin
            any_req_s = 1'b0;
            pick_s    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; RESP waits for the consumer before arbitration resumes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE:   state_nxt_s = CAPT;
            CAPT:    state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: grant strobe in IDLE, capture strobe in CAPT.
    always_comb begin
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE:    accept_s  = any_req_s & ~rst;
            CAPT:    capture_s = ~rst;
            default: begin
                accept_s  = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    assign req0_ready = accept_s & ~pick_s;
    assign req1_ready = accept_s & pick_s;
    assign rsp_valid  = (state_r == RESP);
    assign busy       = (state_r != IDLE);

    // Latch the winning request; the ALU sees only these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r         <= 5'd0;
            a_r          <= 16'd0;
            b_r          <= 16'd0;
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            op_r         <= pick_s ? req1_op : req0_op;
            a_r          <= pick_s ? req1_a  : req0_a;
            b_r          <= pick_s ? req1_b  : req0_b;
            grant_id_r   <= pick_s;
            last_grant_r <= pick_s;
        end
    end

    // Per-requester status contexts; only the granted one is ever written.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx0_r <= STATUS_INIT;
            ctx1_r <= STATUS_INIT;
        end else if (capture_s) begin
            if (grant_id_r) begin
                ctx1_r <= alu_status_out;
            end else begin
                ctx0_r <= alu_status_out;
            end
        end
    end

    // Response capture from the ALU result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id_r     <= 1'b0;
            rsp_c0_r     <= 16'd0;
            rsp_c1_r     <= 16'd0;
            rsp_status_r <= 5'd0;
        end else if (capture_s) begin
            rsp_id_r     <= grant_id_r;
            rsp_c0_r     <= alu_c0;
            rsp_c1_r     <= alu_c1;
            rsp_status_r <= alu_status_out;
        end
    end

    assign alu_a         = a_r;
    assign alu_b         = b_r;
    assign alu_op        = op_r;
    assign alu_status_in = grant_id_r ? ctx1_r : ctx0_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_c0        = rsp_c0_r;
    assign rsp_c1        = rsp_c1_r;
    assign rsp_status    = rsp_status_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench; a small registered ALU model sits behind the DUT,
// expected responses are hand-computed constants queued at grant time and checked by a monitor.
module tb_alu_arbiter;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [4:0]  st;
    } item_t;

    typedef struct packed {
        logic        id;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [4:0]  st;
        logic [31:0] acc;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_op, alu_status_in;
    logic [15:0] alu_c0, alu_c1;
    logic [4:0]  alu_status_out;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_c0, rsp_c1;
    logic [4:0]  rsp_status;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic        prev_v = 1'b0;
    sb_t         sb_q[$];
    sb_t         mon_e;
    item_t       none_i = '0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_status_in(alu_status_in),
        .alu_c0(alu_c0), .alu_c1(alu_c1), .alu_status_out(alu_status_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c0(rsp_c0), .rsp_c1(rsp_c1), .rsp_status(rsp_status),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU environment: status {nan, parity, borrow, zero, carry}.
    function automatic logic [36:0] alu_eval(input logic [4:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [4:0] st);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] c0, c1;
        logic        cy, bw;
        s = 17'd0; p = 32'd0; c0 = 16'd0; c1 = 16'd0; cy = st[0]; bw = 1'b0;
        case (op)
            5'd0:  begin s = {1'b0, a} + {1'b0, b}; c0 = s[15:0]; cy = s[16]; end
            5'd1:  begin s = {1'b0, a} + {1'b0, b} + {16'd0, st[0]}; c0 = s[15:0]; cy = s[16]; end
            5'd2:  begin c0 = a - b; bw = (a < b); end
            5'd6:  begin p = {16'd0, a} * {16'd0, b}; c0 = p[15:0]; c1 = p[31:16]; cy = |c1; end
            5'd22: begin c0 = a; cy = 1'b1; end
            default: c0 = a ^ b;
        endcase
        return {1'b0, ^c0, bw, (c0 == 16'd0), cy, c1, c0};
    endfunction

    always @(posedge clk) {alu_status_out, alu_c1, alu_c0} <= alu_eval(alu_op, alu_a, alu_b, alu_status_in);

    function automatic item_t mk(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c0, input logic [15:0] c1, input logic [4:0] st);
        item_t it;
        it.op = op; it.a = a; it.b = b; it.c0 = c0; it.c1 = c1; it.st = st;
        return it;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on first valid cycle, field compare on handshake.
    always begin
        @(negedge clk);
        #2;
        if (rsp_valid && !prev_v) begin
            if (sb_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
            else                  chk("latency", cyc - sb_q[0].acc, 64'd3);
        end
        if (rsp_valid && rsp_ready && sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("rsp_id", rsp_id, mon_e.id);
            chk("rsp_c0", rsp_c0, mon_e.c0);
            chk("rsp_c1", rsp_c1, mon_e.c1);
            chk("rsp_status", rsp_status, mon_e.st);
        end
        prev_v = rsp_valid;
    end

    // Present requests until one is granted, queue its expected response, check ALU drive.
    task automatic offer(input logic v0, input item_t i0, input logic v1, input item_t i1,
                         input logic exp_id, input int exp_gap);
        logic  got;
        logic  gid;
        item_t w;
        sb_t   e;
        got = 1'b0; gid = 1'b0; w = '0;
        @(negedge clk);
        req0_valid = v0; req0_op = i0.op; req0_a = i0.a; req0_b = i0.b;
        req1_valid = v1; req1_op = i1.op; req1_a = i1.a; req1_b = i1.b;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got = 1'b1;
                gid = req1_ready;
                chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
                chk("grant_id", gid, exp_id);
                if (exp_gap != 0) chk("issue_gap", cyc - last_acc, exp_gap);
                last_acc = cyc;
                w = gid ? i1 : i0;
                e.id = gid; e.c0 = w.c0; e.c1 = w.c1; e.st = w.st; e.acc = cyc;
                sb_q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            chk("alu_op", alu_op, w.op);
            chk("alu_a", alu_a, w.a);
            chk("alu_b", alu_b, w.b);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            #3;
            ok = (sb_q.size() == 0) && !busy;
        end
        chk("drain", ok, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = 5'd0; req0_a = 16'd0; req0_b = 16'd0;
        req1_op = 5'd0; req1_a = 16'd0; req1_b = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", {rsp_id, rsp_c0, rsp_c1, rsp_status}, 38'd0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 37'd0);
        req0_valid = 1'b0;
        rst = 1'b0;

        // Single add, then carry-in proves req0 context holds carry=1.
        offer(1'b1, mk(5'd0, 16'hFFFF, 16'hFFFA, 16'hFFF9, 16'h0, 5'h01), 1'b0, none_i, 1'b0, 0);
        drain();
        offer(1'b1, mk(5'd1, 16'h0, 16'h0, 16'h0001, 16'h0, 5'h08), 1'b0, none_i, 1'b0, 0);
        drain();

        // Tie after reset: grants 0,1,0,1 at the minimum 4-cycle interval.
        do_reset();
        offer(1'b1, mk(5'd2, 16'd10, 16'd3, 16'h0007, 16'h0, 5'h08),
              1'b1, mk(5'd31, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0, 5'h00), 1'b0, 0);
        offer(1'b1, mk(5'd0, 16'h8000, 16'h8000, 16'h0000, 16'h0, 5'h03),
              1'b1, mk(5'd31, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0, 5'h00), 1'b1, 4);
        offer(1'b1, mk(5'd0, 16'h8000, 16'h8000, 16'h0000, 16'h0, 5'h03),
              1'b1, mk(5'd2, 16'd3, 16'd5, 16'hFFFE, 16'h0, 5'h0C), 1'b0, 4);
        offer(1'b1, mk(5'd1, 16'd1, 16'd1, 16'h0003, 16'h0, 5'h00),
              1'b1, mk(5'd2, 16'd3, 16'd5, 16'hFFFE, 16'h0, 5'h0C), 1'b1, 4);
        drain();

        // Context isolation: req1 sets carry, req0 still adds with carry 0.
        do_reset();
        offer(1'b0, none_i, 1'b1, mk(5'd22, 16'h1234, 16'h0, 16'h1234, 16'h0, 5'h09), 1'b1, 0);
        offer(1'b1, mk(5'd1, 16'd1, 16'd1, 16'h0002, 16'h0, 5'h08), 1'b0, none_i, 1'b0, 0);
        offer(1'b0, none_i, 1'b1, mk(5'd1, 16'd1, 16'd1, 16'h0003, 16'h0, 5'h00), 1'b1, 0);
        drain();

        // Backpressure: response held while a requester waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        offer(1'b1, mk(5'd0, 16'h00FF, 16'h0001, 16'h0100, 16'h0, 5'h08), 1'b0, none_i, 1'b0, 0);
        for (int n = 0; n < 10 && !rsp_valid; n++) begin
            @(negedge clk);
            #1;
        end
        chk("bp_valid_seen", rsp_valid, 1'b1);
        req1_valid = 1'b1; req1_op = 5'd0; req1_a = 16'd7; req1_b = 16'd7;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_c0", rsp_c0, 16'h0100);
            chk("bp_status", rsp_status, 5'h08);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
            chk("bp_busy", busy, 1'b1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_valid", rsp_valid, 1'b0);

        // Multiply.
        offer(1'b0, none_i, 1'b1, mk(5'd6, 16'hFFFF, 16'hFFFA, 16'h0006, 16'hFFF9, 5'h01), 1'b1, 0);
        drain();

        // Reset in CAPT: set req0 carry first so the context clear is visible.
        offer(1'b1, mk(5'd22, 16'h0, 16'h0, 16'h0000, 16'h0, 5'h03), 1'b0, none_i, 1'b0, 0);
        drain();
        offer(1'b0, none_i, 1'b1, mk(5'd0, 16'd5, 16'd6, 16'd11, 16'h0, 5'h00), 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        sb_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        offer(1'b1, mk(5'd1, 16'd1, 16'd1, 16'h0002, 16'h0, 5'h08),
              1'b1, mk(5'd1, 16'd2, 16'd2, 16'h0004, 16'h0, 5'h08), 1'b0, 0);
        offer(1'b1, mk(5'd31, 16'h1, 16'h1, 16'h0000, 16'h0, 5'h02),
              1'b1, mk(5'd1, 16'd2, 16'd2, 16'h0004, 16'h0, 5'h08), 1'b1, 4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
